// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage of the P6 pipeline.
//   - fetch_state_e : F-stage FSM encoding (S_FETCH / S_HOLD)
//   - EXC_NONE / EXC_ADEL : IF/ID exception codes
//   - *_DEFAULT : default reset PC and legal instruction-memory window
//   - in_im_window() : word-aligned, in-window address test used by the
//     optional fetch address check (IF_ADEL_CHECK_EN)
package fetch_stage_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,  // request outstanding, address held until i_im_ready
    S_HOLD  = 1'b1   // word parked while the pipeline is stalled
  } fetch_state_e;

  localparam logic [4:0]  EXC_NONE          = 5'd0;
  localparam logic [4:0]  EXC_ADEL          = 5'd4;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEFAULT  = 32'h0000_4000;

  // Subtraction form avoids overflow when base + bytes wraps past 2^32.
  function automatic logic in_im_window(input logic [31:0] pc,
                                        input logic [31:0] base,
                                        input logic [31:0] bytes);
    logic [31:0] offs;
    offs = pc - base;
    return (pc[1:0] == 2'b00) && (pc >= base) && (offs < bytes);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_load             : capture {instr, pc, pc+4, exc} and mark valid
//   i_bubble           : insert a nop (instr=0, valid=0, exc=0); pc fields hold
//   (neither)          : hold current contents
//   i_instr/i_pc/i_exc : values from F
//   o_instr/o_pc/o_pc4/o_valid/o_exc : registered D-stage view
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_exc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc4,
  output logic        o_valid,
  output logic [4:0]  o_exc
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr <= '0;
      o_pc    <= '0;
      o_pc4   <= '0;
      o_valid <= 1'b0;
      o_exc   <= EXC_NONE;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_pc    <= i_pc;
      o_pc4   <= i_pc + 32'd4;  // natural 32-bit wrap
      o_valid <= 1'b1;
      o_exc   <= i_exc;
    end else if (i_bubble) begin
      o_instr <= '0;
      o_valid <= 1'b0;
      o_exc   <= EXC_NONE;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// F stage: PC register, IM request/response handshake, IF/ID register.
// Optional feature macro: IF_ADEL_CHECK_EN (misaligned / out-of-window
// fetch raises AdEL instead of issuing a request).
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_stall                : hold IF/ID and PC
//   i_npc_sel, i_nextPC    : next-PC unit select and result
//   o_PC                   : current fetch PC
//   o_im_req, o_im_addr    : IM read request / address
//   i_im_ready, i_im_rdata : IM response
//   o_instr_D, o_PC_D, o_PC4_D, o_valid_D, o_exc_D : IF/ID contents
//   o_dbg_state, o_dbg_redir_v : FSM state and pending-redirect flag
// Handshake: the IM word is taken in any cycle where o_im_req=1 and
// i_im_ready=1; o_im_addr stays stable from the first request cycle until
// that cycle. i_im_ready is ignored while o_im_req=0.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_BYTES = IM_BYTES_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_stall,
  input  logic         i_npc_sel,
  input  logic [31:0]  i_nextPC,
  output logic [31:0]  o_PC,
  output logic         o_im_req,
  output logic [31:0]  o_im_addr,
  input  logic         i_im_ready,
  input  logic [31:0]  i_im_rdata,
  output logic [31:0]  o_instr_D,
  output logic [31:0]  o_PC_D,
  output logic [31:0]  o_PC4_D,
  output logic         o_valid_D,
  output logic [4:0]   o_exc_D,
  output fetch_state_e o_dbg_state,
  output logic         o_dbg_redir_v
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  hold_word, hold_word_nxt;
  logic         redir_v, redir_v_nxt;
  logic [31:0]  redir_pc, redir_pc_nxt;
  logic         adel;
  logic         got_word, avail, accept, park;
  logic         load, bubble;
  logic [31:0]  word;
  logic [4:0]   exc;

`ifdef IF_ADEL_CHECK_EN
  // A bad address never reaches IM; only relevant while fetching, since a
  // parked word already came from a legal address.
  assign adel = (state == S_FETCH) && !in_im_window(pc, IM_BASE, IM_BYTES);
`else
  logic unused_cfg;
  assign adel       = 1'b0;
  assign unused_cfg = ^{IM_BASE, IM_BYTES};
`endif

  assign o_im_req  = (state == S_FETCH) && !adel;
  assign o_im_addr = pc;
  assign o_PC      = pc;

  assign got_word = o_im_req && i_im_ready;
  assign avail    = got_word || (state == S_HOLD) || adel;
  assign accept   = avail && !i_stall;
  // Only a real IM word is parked; an AdEL slot simply re-evaluates.
  assign park     = got_word && i_stall;

  assign word = (state == S_HOLD) ? hold_word : (adel ? 32'd0 : i_im_rdata);
  assign exc  = adel ? EXC_ADEL : EXC_NONE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      hold_word <= '0;
      redir_v   <= 1'b0;
      redir_pc  <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      hold_word <= hold_word_nxt;
      redir_v   <= redir_v_nxt;
      redir_pc  <= redir_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    hold_word_nxt = hold_word;
    redir_v_nxt   = redir_v;
    redir_pc_nxt  = redir_pc;
    load          = 1'b0;
    bubble        = 1'b0;
    if (accept) begin
      load        = 1'b1;
      pc_nxt      = redir_v ? redir_pc : i_nextPC;
      redir_v_nxt = 1'b0;
      state_nxt   = S_FETCH;
    end else if (park) begin
      hold_word_nxt = i_im_rdata;
      state_nxt     = S_HOLD;
    end else if (!avail && !i_stall) begin
      bubble = 1'b1;
      // The branch leaves D before its delay slot arrives, so its target
      // must be remembered until the delay slot is accepted.
      if (o_valid_D && i_npc_sel) begin
        redir_pc_nxt = i_nextPC;
        redir_v_nxt  = 1'b1;
      end
    end
  end

  if_id_reg u_if_id (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_load   (load),
    .i_bubble (bubble),
    .i_instr  (word),
    .i_pc     (pc),
    .i_exc    (exc),
    .o_instr  (o_instr_D),
    .o_pc     (o_PC_D),
    .o_pc4    (o_PC4_D),
    .o_valid  (o_valid_D),
    .o_exc    (o_exc_D)
  );

  assign o_dbg_state   = state;
  assign o_dbg_redir_v = redir_v;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  // ---------------- clock / reset / signals ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         stall = 1'b0;
  logic         npc_sel = 1'b0;
  logic         npc_ovr_en = 1'b0;
  logic [31:0]  npc_ovr = '0;
  logic         im_ready = 1'b0;
  logic [31:0]  next_pc;
  logic [31:0]  im_rdata;
  logic [31:0]  pc, im_addr, instr_d, pc_d, pc4_d;
  logic         im_req, valid_d, redir_v;
  logic [4:0]   exc_d;
  fetch_state_e st;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // IM returns a word tagged with its address; next-PC unit defaults to PC+4.
  assign im_rdata = im_addr ^ 32'hC0DE_0000;
  assign next_pc  = npc_ovr_en ? npc_ovr : pc + 32'd4;

  fetch_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_npc_sel(npc_sel),
    .i_nextPC(next_pc), .o_PC(pc), .o_im_req(im_req), .o_im_addr(im_addr),
    .i_im_ready(im_ready), .i_im_rdata(im_rdata), .o_instr_D(instr_d),
    .o_PC_D(pc_d), .o_PC4_D(pc4_d), .o_valid_D(valid_d), .o_exc_D(exc_d),
    .o_dbg_state(st), .o_dbg_redir_v(redir_v)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; npc_sel = 1'b0; npc_ovr_en = 1'b0;
    npc_ovr = '0; im_ready = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    im_ready = 1'b1;
    step(); step();
    stall = 1'b1;
    step();                        // word at 0x3008 parked in S_HOLD
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (pc !== 32'h3000) begin errs++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
    vecs++; if (valid_d !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", valid_d); end
    vecs++; if (exc_d !== 5'd0) begin errs++; $display("FAIL rst_exc got=%0d exp=0", exc_d); end
    vecs++; if (st !== S_FETCH || redir_v !== 1'b0) begin errs++; $display("FAIL rst_state got=%0d/%b exp=0/0", st, redir_v); end
    stall = 1'b0; im_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    vecs++; if (im_req !== 1'b1 || im_addr !== 32'h3000) begin errs++; $display("FAIL rst_req got=%b/%h exp=1/00003000", im_req, im_addr); end
    vecs++; if (instr_d !== 32'd0 || pc_d !== 32'd0 || pc4_d !== 32'd0) begin errs++; $display("FAIL rst_ifid got=%h/%h/%h exp=0/0/0", instr_d, pc_d, pc4_d); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h3000; exp_pc[1] = 32'h3004; exp_pc[2] = 32'h3008;
    do_reset();
    im_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (pc_d !== exp_pc[i] || valid_d !== 1'b1) begin errs++; $display("FAIL zw_pc_d[%0d] got=%h/%b exp=%h/1", i, pc_d, valid_d, exp_pc[i]); end
      vecs++; if (instr_d !== (exp_pc[i] ^ 32'hC0DE_0000) || pc4_d !== exp_pc[i] + 32'd4) begin errs++; $display("FAIL zw_word[%0d] got=%h/%h", i, instr_d, pc4_d); end
    end
    vecs++; if (pc !== 32'h300C) begin errs++; $display("FAIL zw_pc got=%h exp=0000300c", pc); end
  endtask

  task automatic test_stall_hold();
    do_reset();
    im_ready = 1'b1;
    step();                        // D = 0x3000, PC = 0x3004
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      im_ready = 1'b0;             // ignored while parked
      vecs++; if (st !== S_HOLD || im_req !== 1'b0 || pc !== 32'h3004) begin errs++; $display("FAIL hold[%0d] got st=%0d req=%b pc=%h exp 1/0/00003004", i, st, im_req, pc); end
      vecs++; if (pc_d !== 32'h3000 || valid_d !== 1'b1) begin errs++; $display("FAIL hold_ifid[%0d] got=%h/%b exp=00003000/1", i, pc_d, valid_d); end
    end
    stall = 1'b0;
    step();
    vecs++; if (pc_d !== 32'h3004 || instr_d !== 32'hC0DE_3004 || valid_d !== 1'b1) begin errs++; $display("FAIL hold_release got=%h/%h/%b exp=00003004/c0de3004/1", pc_d, instr_d, valid_d); end
    vecs++; if (pc !== 32'h3008 || st !== S_FETCH || im_req !== 1'b1) begin errs++; $display("FAIL hold_pc got=%h/%0d/%b exp=00003008/0/1", pc, st, im_req); end
  endtask

  task automatic test_branch_latency();
    do_reset();
    im_ready = 1'b1;
    step();                        // beq @0x3000 in D, PC = 0x3004
    im_ready = 1'b0; npc_sel = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3100;
    step();                        // delay slot not ready: bubble, capture target
    vecs++; if (valid_d !== 1'b0 || instr_d !== 32'd0 || redir_v !== 1'b1) begin errs++; $display("FAIL br_bubble got=%b/%h/%b exp=0/0/1", valid_d, instr_d, redir_v); end
    vecs++; if (pc !== 32'h3004) begin errs++; $display("FAIL br_pc_hold got=%h exp=00003004", pc); end
    npc_ovr_en = 1'b0;             // next-PC now sees the bubble: PC+4
    step();                        // still waiting; bubble in D must not re-redirect
    vecs++; if (redir_v !== 1'b1 || pc !== 32'h3004) begin errs++; $display("FAIL br_wait got=%b/%h exp=1/00003004", redir_v, pc); end
    im_ready = 1'b1;
    step();
    vecs++; if (pc_d !== 32'h3004 || valid_d !== 1'b1) begin errs++; $display("FAIL br_slot got=%h/%b exp=00003004/1", pc_d, valid_d); end
    vecs++; if (pc !== 32'h3100 || redir_v !== 1'b0) begin errs++; $display("FAIL br_target got=%h/%b exp=00003100/0", pc, redir_v); end
    npc_sel = 1'b0;
  endtask

  task automatic test_branch_same_cycle();
    do_reset();
    im_ready = 1'b1;
    step();
    npc_sel = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3100;
    step();
    vecs++; if (pc !== 32'h3100 || redir_v !== 1'b0 || pc_d !== 32'h3004) begin errs++; $display("FAIL br_same got=%h/%b/%h exp=00003100/0/00003004", pc, redir_v, pc_d); end
    npc_sel = 1'b0; npc_ovr_en = 1'b0;
  endtask

  task automatic test_bubble_no_redirect();
    do_reset();
    npc_sel = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3200;
    step();                        // D empty: select must be ignored
    vecs++; if (redir_v !== 1'b0 || pc !== 32'h3000) begin errs++; $display("FAIL nored got=%b/%h exp=0/00003000", redir_v, pc); end
    npc_sel = 1'b0; npc_ovr_en = 1'b0; im_ready = 1'b1;
    step();
    vecs++; if (pc !== 32'h3004 || pc_d !== 32'h3000) begin errs++; $display("FAIL nored_next got=%h/%h exp=00003004/00003000", pc, pc_d); end
  endtask

  task automatic test_stall_no_capture();
    do_reset();
    im_ready = 1'b1;
    step();
    im_ready = 1'b0; stall = 1'b1; npc_sel = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3300;
    step();
    vecs++; if (redir_v !== 1'b0 || pc !== 32'h3004 || pc_d !== 32'h3000 || valid_d !== 1'b1) begin errs++; $display("FAIL stall_nocap got=%b/%h/%h/%b exp=0/00003004/00003000/1", redir_v, pc, pc_d, valid_d); end
    stall = 1'b0; npc_sel = 1'b0; npc_ovr_en = 1'b0;
  endtask

`ifdef IF_ADEL_CHECK_EN
  task automatic test_adel();
    do_reset();
    im_ready = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'h3002;
    step();                        // PC = 0x3002 (misaligned)
    vecs++; if (im_req !== 1'b0 || pc !== 32'h3002) begin errs++; $display("FAIL adel_req got=%b/%h exp=0/00003002", im_req, pc); end
    npc_ovr = 32'h3004;
    step();
    vecs++; if (instr_d !== 32'd0 || valid_d !== 1'b1 || exc_d !== 5'd4 || pc_d !== 32'h3002) begin errs++; $display("FAIL adel_ifid got=%h/%b/%0d/%h exp=0/1/4/00003002", instr_d, valid_d, exc_d, pc_d); end
    npc_ovr_en = 1'b0;
  endtask
`else
  task automatic test_pc_wrap();
    do_reset();
    im_ready = 1'b1; npc_ovr_en = 1'b1; npc_ovr = 32'hFFFF_FFFC;
    step();
    npc_ovr_en = 1'b0;
    step();
    vecs++; if (pc_d !== 32'hFFFF_FFFC || pc4_d !== 32'd0 || pc !== 32'd0) begin errs++; $display("FAIL wrap got=%h/%h/%h exp=fffffffc/0/0", pc_d, pc4_d, pc); end
    vecs++; if (exc_d !== 5'd0) begin errs++; $display("FAIL wrap_exc got=%0d exp=0", exc_d); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_stall_hold();
    test_branch_latency();
    test_branch_same_cycle();
    test_bubble_no_redirect();
    test_stall_no_capture();
`ifdef IF_ADEL_CHECK_EN
    test_adel();
`else
    test_pc_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
